// File: rtl/keypad_frame_tx_pkg.sv
// Shared constants and TX state encoding for the keypad frame transmitter.
package keypad_frame_tx_pkg;

    localparam logic [7:0] ASCII_ZERO = 8'h30;
    localparam logic [7:0] FRAME_TERM = 8'h0D;
    localparam int         FRAME_LEN  = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

    function automatic logic [7:0] to_ascii(input logic [3:0] d);
        return ASCII_ZERO + {4'd0, d};
    endfunction

endpackage

// File: rtl/keypad_frame_tx_uart_byte_tx.sv
// 8N1 byte serialiser; ready rises in the last stop-bit cycle so the
// next byte can follow with no idle gap.
module uart_byte_tx
    import keypad_frame_tx_pkg::*;
#(
    parameter int DIV = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] data,
    input  logic       start,
    output logic       txd,
    output logic       ready
);

    localparam int CW = $clog2(DIV);
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    tx_state_t   state;
    tx_state_t   state_nx;
    logic [CW-1:0] cnt;
    logic [2:0]  bit_idx;
    logic [7:0]  shreg;
    logic        bit_end;
    logic        load;

    assign bit_end = (cnt == LAST);
    assign load    = start && ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:  if (start) state_nx = START;
            START: if (bit_end) state_nx = DATA;
            DATA: begin
                if (bit_end && bit_idx == 3'd7) begin
                    state_nx = STOP;
                end
            end
            STOP: begin
                if (bit_end) begin
                    state_nx = start ? START : IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        txd   = 1'b1;
        ready = 1'b0;
        unique case (state)
            IDLE:    ready = 1'b1;
            START:   txd   = 1'b0;
            DATA:    txd   = shreg[0];
            STOP:    ready = bit_end;
            default: ready = 1'b0;
        endcase
    end

    // Counter restarts at every bit boundary and sits at zero in IDLE.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt     <= '0;
            bit_idx <= '0;
            shreg   <= '0;
        end else begin
            if (state == IDLE || bit_end) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
            if (load) begin
                shreg   <= data;
                bit_idx <= '0;
            end else if (state == DATA && bit_end) begin
                shreg   <= {1'b0, shreg[7:1]};
                bit_idx <= bit_idx + 1'b1;
            end
        end
    end

endmodule

// File: rtl/keypad_frame_tx.sv
// Keypad entry buffer plus 5-byte ASCII frame sender over UART 8N1.
module keypad_frame_tx
    import keypad_frame_tx_pkg::*;
#(
    parameter int CLK_FREQ = 50000000,
    parameter int BAUD     = 9600
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] num,
    input  logic       numPressed,
    input  logic       clear,
    input  logic       submit,
    output logic [3:0] num1,
    output logic [3:0] num2,
    output logic [3:0] num3,
    output logic [3:0] num4,
    output logic       txd,
    output logic       busy,
    output logic       done
);

    localparam int DIV = CLK_FREQ / BAUD;
    localparam int FW  = (FRAME_LEN - 1) * 8;

    logic [FW-1:0] frame;
    logic [2:0]    byte_idx;
    logic          accept;
    logic          byte_end;
    logic          last_byte;
    logic          tx_start;
    logic          tx_ready;
    logic [7:0]    tx_data;

    assign accept    = submit && !clear && !busy && !done;
    assign byte_end  = busy && tx_ready;
    assign last_byte = (byte_idx == 3'(FRAME_LEN - 1));
    assign tx_start  = accept || (byte_end && !last_byte);
    assign tx_data   = accept ? to_ascii(num1) : frame[FW-1 -: 8];

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            num1 <= '0;
            num2 <= '0;
            num3 <= '0;
            num4 <= '0;
        end else if (numPressed && !submit && num <= 4'd9) begin
            num1 <= num2;
            num2 <= num3;
            num3 <= num4;
            num4 <= num;
        end
    end

    // First byte goes straight to the serialiser; the rest wait here.
    always_ff @(posedge clk) begin
        if (reset) begin
            busy     <= 1'b0;
            done     <= 1'b0;
            byte_idx <= '0;
            frame    <= '0;
        end else begin
            done <= 1'b0;
            if (accept) begin
                busy     <= 1'b1;
                byte_idx <= '0;
                frame    <= {to_ascii(num2), to_ascii(num3),
                             to_ascii(num4), FRAME_TERM};
            end else if (byte_end) begin
                if (last_byte) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end else begin
                    byte_idx <= byte_idx + 1'b1;
                    frame    <= frame << 8;
                end
            end
        end
    end

    uart_byte_tx #(
        .DIV(DIV)
    ) u_tx (
        .clk   (clk),
        .reset (reset),
        .data  (tx_data),
        .start (tx_start),
        .txd   (txd),
        .ready (tx_ready)
    );

endmodule

// File: tb/tb_keypad_frame_tx.sv
// Bench for keypad_frame_tx: entry table, UART decode scoreboard, corners.
module tb_keypad_frame_tx;

    logic       clk;
    logic       reset;
    logic [3:0] num;
    logic       numPressed;
    logic       clear;
    logic       submit;
    logic [3:0] num1;
    logic [3:0] num2;
    logic [3:0] num3;
    logic [3:0] num4;
    logic       txd;
    logic       busy;
    logic       done;

    int pass_cnt;
    int total_cnt;
    int done_cnt;
    int abort_gen;
    logic [7:0] sb[$];

    keypad_frame_tx #(
        .CLK_FREQ(16),
        .BAUD    (1)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .num        (num),
        .numPressed (numPressed),
        .clear      (clear),
        .submit     (submit),
        .num1       (num1),
        .num2       (num2),
        .num3       (num3),
        .num4       (num4),
        .txd        (txd),
        .busy       (busy),
        .done       (done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] want);
        total_cnt++;
        if (act === want) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h", name, act, want);
        end
    endtask

    function automatic logic [15:0] bufv();
        return {num1, num2, num3, num4};
    endfunction

    task automatic drive(input logic c, input logic s,
                         input logic p, input logic [3:0] n);
        clear      = c;
        submit     = s;
        numPressed = p;
        num        = n;
        @(posedge clk);
        #1;
        clear      = 1'b0;
        submit     = 1'b0;
        numPressed = 1'b0;
        num        = 4'd0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 4'd0);
    endtask

    task automatic push_frame(input logic [15:0] d);
        sb.push_back(8'h30 + {4'd0, d[15:12]});
        sb.push_back(8'h30 + {4'd0, d[11:8]});
        sb.push_back(8'h30 + {4'd0, d[7:4]});
        sb.push_back(8'h30 + {4'd0, d[3:0]});
        sb.push_back(8'h0D);
    endtask

    task automatic load_buf(input logic [15:0] d);
        drive(1'b1, 1'b0, 1'b0, 4'd0);
        drive(1'b0, 1'b0, 1'b1, d[15:12]);
        drive(1'b0, 1'b0, 1'b1, d[11:8]);
        drive(1'b0, 1'b0, 1'b1, d[7:4]);
        drive(1'b0, 1'b0, 1'b1, d[3:0]);
    endtask

    task automatic wait_frame(output int n);
        n = 0;
        while (busy && n < 2000) begin
            drive(1'b0, 1'b0, 1'b0, 4'd0);
            n++;
        end
    endtask

    initial begin
        forever @(negedge clk) if (done === 1'b1) done_cnt++;
    end

    // Decode each UART byte at bit mid-points and match against the queue.
    initial begin : monitor
        logic [7:0] b;
        logic s0;
        logic s1;
        int gen;
        forever begin
            @(posedge clk);
            #1;
            if (reset === 1'b0 && txd === 1'b0) begin
                gen = abort_gen;
                repeat (8) @(posedge clk);
                #1;
                s0 = txd;
                for (int i = 0; i < 8; i++) begin
                    repeat (16) @(posedge clk);
                    #1;
                    b[i] = txd;
                end
                repeat (16) @(posedge clk);
                #1;
                s1 = txd;
                if (gen == abort_gen) begin
                    chk("start_bit", {31'd0, s0}, 32'd0);
                    chk("stop_bit", {31'd0, s1}, 32'd1);
                    if (sb.size() == 0) begin
                        total_cnt++;
                        $display("FAIL stray_byte: got %0h, expected none", b);
                    end else begin
                        chk("rx_byte", {24'd0, b}, {24'd0, sb.pop_front()});
                    end
                end
            end
        end
    end

    typedef struct {
        logic        clr;
        logic        np;
        logic [3:0]  n;
        logic [15:0] want;
    } vec_t;

    vec_t vec[12];
    int   len;
    int   d0;

    initial begin
        pass_cnt   = 0;
        total_cnt  = 0;
        done_cnt   = 0;
        abort_gen  = 0;
        reset      = 1'b1;
        clear      = 1'b0;
        submit     = 1'b0;
        numPressed = 1'b0;
        num        = 4'd0;

        vec[0]  = '{1'b0, 1'b1, 4'd1,  16'h0001};
        vec[1]  = '{1'b0, 1'b1, 4'd2,  16'h0012};
        vec[2]  = '{1'b0, 1'b1, 4'd3,  16'h0123};
        vec[3]  = '{1'b0, 1'b1, 4'd4,  16'h1234};
        vec[4]  = '{1'b0, 1'b1, 4'd5,  16'h2345};
        vec[5]  = '{1'b0, 1'b1, 4'd12, 16'h2345};
        vec[6]  = '{1'b0, 1'b1, 4'd15, 16'h2345};
        vec[7]  = '{1'b1, 1'b0, 4'd0,  16'h0000};
        vec[8]  = '{1'b0, 1'b1, 4'd9,  16'h0009};
        vec[9]  = '{1'b1, 1'b1, 4'd7,  16'h0000};
        vec[10] = '{1'b0, 1'b1, 4'd0,  16'h0000};
        vec[11] = '{1'b0, 1'b1, 4'd7,  16'h0007};

        idle(3);
        chk("rst_txd", {31'd0, txd}, 32'd1);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_buf", {16'd0, bufv()}, 32'd0);
        reset = 1'b0;
        idle(2);

        for (int i = 0; i < 12; i++) begin
            drive(vec[i].clr, 1'b0, vec[i].np, vec[i].n);
            chk($sformatf("entry%0d", i), {16'd0, bufv()},
                {16'd0, vec[i].want});
        end

        // Frame 0427 with submit, digit and clear events mid-frame.
        load_buf(16'h0427);
        chk("preload", {16'd0, bufv()}, 32'h0427);
        push_frame(16'h0427);
        d0 = done_cnt;
        drive(1'b0, 1'b1, 1'b0, 4'd0);
        chk("busy_rise", {31'd0, busy}, 32'd1);
        chk("start_low", {31'd0, txd}, 32'd0);
        len = 0;
        while (busy && len < 2000) begin
            if (len == 100) drive(1'b0, 1'b1, 1'b0, 4'd0);
            else if (len == 200) drive(1'b0, 1'b0, 1'b1, 4'd9);
            else if (len == 300) drive(1'b1, 1'b0, 1'b0, 4'd0);
            else drive(1'b0, 1'b0, 1'b0, 4'd0);
            len++;
            if (len == 201) chk("mid_digit", {16'd0, bufv()}, 32'h4279);
            if (len == 301) chk("mid_clear", {16'd0, bufv()}, 32'h0000);
        end
        chk("frame_len", len, 32'd800);
        chk("done_at_fall", {31'd0, done}, 32'd1);
        idle(40);
        chk("done_once", done_cnt - d0, 32'd1);
        chk("sb_empty_a", sb.size(), 32'd0);
        chk("no_refire", {31'd0, busy}, 32'd0);

        // clear wins over submit; submit wins over numPressed.
        load_buf(16'h1234);
        drive(1'b1, 1'b1, 1'b0, 4'd0);
        chk("clr_sub_buf", {16'd0, bufv()}, 32'd0);
        chk("clr_sub_busy", {31'd0, busy}, 32'd0);
        idle(200);
        load_buf(16'h1234);
        push_frame(16'h1234);
        drive(1'b0, 1'b1, 1'b1, 4'd8);
        chk("sub_np_busy", {31'd0, busy}, 32'd1);
        chk("sub_np_buf", {16'd0, bufv()}, 32'h1234);
        wait_frame(len);
        chk("frame_len_b", len, 32'd800);

        // Submit on the done cycle is dropped; the next cycle is taken.
        chk("done_b", {31'd0, done}, 32'd1);
        drive(1'b0, 1'b1, 1'b0, 4'd0);
        chk("sub_on_done", {31'd0, busy}, 32'd0);
        push_frame(16'h1234);
        drive(1'b0, 1'b1, 1'b0, 4'd0);
        chk("b2b_busy", {31'd0, busy}, 32'd1);
        chk("b2b_start", {31'd0, txd}, 32'd0);
        wait_frame(len);
        chk("frame_len_c", len, 32'd800);
        idle(20);
        chk("sb_empty_c", sb.size(), 32'd0);

        // Reset 300 cycles into a frame aborts it.
        load_buf(16'h5678);
        push_frame(16'h5678);
        drive(1'b0, 1'b1, 1'b0, 4'd0);
        idle(300);
        reset = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 4'd0);
        abort_gen++;
        chk("rst_mid_txd", {31'd0, txd}, 32'd1);
        chk("rst_mid_busy", {31'd0, busy}, 32'd0);
        chk("rst_mid_buf", {16'd0, bufv()}, 32'd0);
        chk("rst_mid_sb", sb.size(), 32'd4);
        sb.delete();
        reset = 1'b0;
        idle(200);
        chk("no_resume", {31'd0, busy}, 32'd0);
        push_frame(16'h0000);
        drive(1'b0, 1'b1, 1'b0, 4'd0);
        chk("post_rst_busy", {31'd0, busy}, 32'd1);
        wait_frame(len);
        chk("frame_len_d", len, 32'd800);
        idle(20);
        chk("sb_empty_d", sb.size(), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
